// File: rtl/demoman_pkg.sv
// Shared types and constants for the sprite ROM path: address/data widths,
// RGB565 field layout and the requester index type.
package demoman_pkg;

    localparam int SPRITE_AW = 16;
    localparam int SPRITE_DW = 16;

    localparam int RGB_R_HI = 15;
    localparam int RGB_R_LO = 11;
    localparam int RGB_G_HI = 10;
    localparam int RGB_G_LO = 5;
    localparam int RGB_B_HI = 4;
    localparam int RGB_B_LO = 0;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic logic [4:0] rgb565_r(input logic [15:0] px);
        return px[RGB_R_HI:RGB_R_LO];
    endfunction

    function automatic logic [5:0] rgb565_g(input logic [15:0] px);
        return px[RGB_G_HI:RGB_G_LO];
    endfunction

    function automatic logic [4:0] rgb565_b(input logic [15:0] px);
        return px[RGB_B_HI:RGB_B_LO];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant unit. Grants are combinational; the last-granted
// pointer is the only state and moves only when a grant is issued.
module rr_arb2
    import demoman_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_idx
);

    req_id_t last;

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (last == REQ1) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign gnt_idx = gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= REQ1;
        end else if (gnt0 || gnt1) begin
            last <= gnt1 ? REQ1 : REQ0;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port between two requesters, tagging
// each read so the returning data is flagged for its owner LAT cycles later.
module sprite_rom_arbiter
    import demoman_pkg::*;
#(
    parameter int AW  = SPRITE_AW,
    parameter int DW  = SPRITE_DW,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic    gnt_idx_raw;
    req_id_t gnt_idx;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_idx (gnt_idx_raw)
    );

    assign gnt_idx  = gnt_idx_raw;
    assign rom_en   = gnt0 | gnt1;
    assign rom_addr = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

    // Stage 0: tag captured alongside the ROM address register
    logic [LAT-1:0] vld_p;
    req_id_t        own_p [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p[0] <= 1'b0;
        end else begin
            vld_p[0] <= rom_en;
        end
    end

    always_ff @(posedge clk) begin
        own_p[0] <= gnt_idx;
    end

    // Stages 1..LAT-1: tag shift matching the ROM read latency
    for (genvar s = 1; s < LAT; s++) begin : g_stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p[s] <= 1'b0;
            end else begin
                vld_p[s] <= vld_p[s-1];
            end
        end

        always_ff @(posedge clk) begin
            own_p[s] <= own_p[s-1];
        end
    end

    assign rvalid0 = vld_p[LAT-1] && (own_p[LAT-1] == REQ0);
    assign rvalid1 = vld_p[LAT-1] && (own_p[LAT-1] == REQ1);
    assign rdata0  = rom_data;
    assign rdata1  = rom_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0 <= 16'd0;
            gcnt1 <= 16'd0;
        end else begin
            if (gnt0) begin
                gcnt0 <= sat_inc(gcnt0);
            end
            if (gnt1) begin
                gcnt1 <= sat_inc(gcnt1);
            end
        end
    end

endmodule
